// File: rtl/watch_mode_controller.sv
// Mode/run-state sequencer between debounced buttons and the timer/stopwatch cores.
// Optional lap-freeze behaviour is compiled in when WATCH_LAP_EN is defined.
module watch_mode_controller #(
  parameter int ALARM_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       start,
  input  logic       stop,
  input  logic       softrst,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       tmr_zero,
  output logic       tmr_start,
  output logic       tmr_stop,
  output logic       tmr_reset,
  output logic       tmr_inc_min,
  output logic       tmr_inc_sec,
  output logic       sw_start,
  output logic       sw_stop,
  output logic       sw_reset,
  output logic       mode,
  output logic       running,
  output logic       alarm,
  output logic       sw_freeze,
  output logic [2:0] state
);

  localparam int CW = $clog2(ALARM_CYCLES + 1);

  typedef enum logic [2:0] {
    TMR_IDLE  = 3'd0,
    TMR_RUN   = 3'd1,
    TMR_ALARM = 3'd2,
    SW_IDLE   = 3'd3,
    SW_RUN    = 3'd4,
    SW_LAP    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE, EV_SOFTRST, EV_STOP, EV_START, EV_MODE, EV_INC_MIN, EV_INC_SEC
  } ev_t;

  typedef struct packed {
    logic tmr_start;
    logic tmr_stop;
    logic tmr_reset;
    logic tmr_inc_min;
    logic tmr_inc_sec;
    logic sw_start;
    logic sw_stop;
    logic sw_reset;
  } cmd_t;

  logic [5:0]    lvl, prev_q, rise;
  ev_t           ev;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic          mode_q, running_q, alarm_q;

  assign lvl  = {softrst, stop, start, mode_btn, inc_min, inc_sec};
  assign rise = lvl & ~prev_q;

  // Only the highest-priority rising edge acts; the rest are discarded this cycle.
  always_comb begin
    ev = EV_NONE;
    if      (rise[5]) ev = EV_SOFTRST;
    else if (rise[4]) ev = EV_STOP;
    else if (rise[3]) ev = EV_START;
    else if (rise[2]) ev = EV_MODE;
    else if (rise[1]) ev = EV_INC_MIN;
    else if (rise[0]) ev = EV_INC_SEC;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = '0;
    case (state_q)
      TMR_IDLE: begin
        case (ev)
          EV_START:   if (!tmr_zero) begin cmd_d.tmr_start = 1'b1; state_d = TMR_RUN; end
          EV_SOFTRST: cmd_d.tmr_reset   = 1'b1;
          EV_INC_MIN: cmd_d.tmr_inc_min = 1'b1;
          EV_INC_SEC: cmd_d.tmr_inc_sec = 1'b1;
          EV_MODE:    state_d = SW_IDLE;
          default: ;
        endcase
      end
      TMR_RUN: begin
        // Expiry outranks any button so the core is always stopped at 00:00.
        if (tmr_zero) begin
          cmd_d.tmr_stop = 1'b1;
          cnt_d          = CW'(ALARM_CYCLES);
          state_d        = TMR_ALARM;
        end else if (ev == EV_STOP) begin
          cmd_d.tmr_stop = 1'b1;
          state_d        = TMR_IDLE;
        end else if (ev == EV_SOFTRST) begin
          cmd_d.tmr_reset = 1'b1;
          cmd_d.tmr_stop  = 1'b1;
          state_d         = TMR_IDLE;
        end
      end
      TMR_ALARM: begin
        if (ev != EV_NONE || cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = TMR_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SW_IDLE: begin
        case (ev)
          EV_START:   begin cmd_d.sw_start = 1'b1; state_d = SW_RUN; end
          EV_SOFTRST: cmd_d.sw_reset = 1'b1;
          EV_MODE:    state_d = TMR_IDLE;
          default: ;
        endcase
      end
      SW_RUN: begin
        case (ev)
          EV_STOP:    begin cmd_d.sw_stop = 1'b1; state_d = SW_IDLE; end
          EV_SOFTRST: begin cmd_d.sw_reset = 1'b1; cmd_d.sw_stop = 1'b1; state_d = SW_IDLE; end
`ifdef WATCH_LAP_EN
          EV_START:   state_d = SW_LAP;
`endif
          default: ;
        endcase
      end
`ifdef WATCH_LAP_EN
      SW_LAP: begin
        case (ev)
          EV_START:   state_d = SW_RUN;
          EV_STOP:    begin cmd_d.sw_stop = 1'b1; state_d = SW_IDLE; end
          EV_SOFTRST: begin cmd_d.sw_reset = 1'b1; cmd_d.sw_stop = 1'b1; state_d = SW_IDLE; end
          default: ;
        endcase
      end
`endif
      default: state_d = TMR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // prev resets high so a button held through reset cannot fire on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '1;
      state_q   <= TMR_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      mode_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      prev_q    <= lvl;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      mode_q    <= (state_d == SW_IDLE) || (state_d == SW_RUN) || (state_d == SW_LAP);
      running_q <= (state_d == TMR_RUN) || (state_d == SW_RUN) || (state_d == SW_LAP);
      alarm_q   <= (state_d == TMR_ALARM);
    end
  end

`ifdef WATCH_LAP_EN
  logic freeze_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) freeze_q <= 1'b0;
    else     freeze_q <= (state_d == SW_LAP);
  end
  assign sw_freeze = freeze_q;
`else
  assign sw_freeze = 1'b0;
`endif

  assign tmr_start   = cmd_q.tmr_start;
  assign tmr_stop    = cmd_q.tmr_stop;
  assign tmr_reset   = cmd_q.tmr_reset;
  assign tmr_inc_min = cmd_q.tmr_inc_min;
  assign tmr_inc_sec = cmd_q.tmr_inc_sec;
  assign sw_start    = cmd_q.sw_start;
  assign sw_stop     = cmd_q.sw_stop;
  assign sw_reset    = cmd_q.sw_reset;
  assign mode        = mode_q;
  assign running     = running_q;
  assign alarm       = alarm_q;
  assign state       = state_q;

endmodule
